// File: rtl/sign_mon_pkg.sv
// Shared types and helpers for the multi-channel sign monitor.
// Classes are ZERO/POS/NEG, and the classifier does not depend on the sample width.
package sign_mon_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_POS  = 2'd1,
    CLS_NEG  = 2'd2
  } cls_t;

  localparam int unsigned MAX_STABLE = 255;

  // Works for any width: the caller passes the sign bit and the OR-reduction of the sample.
  function automatic cls_t classify(input logic i_msb, input logic i_nonzero);
    if (i_msb) begin
      return CLS_NEG;
    end else if (i_nonzero) begin
      return CLS_POS;
    end
    return CLS_ZERO;
  endfunction

endpackage

// File: rtl/sign_mon_chan.sv
// One channel of the sign monitor: classifier, persistence run, one-hot committed flags,
// and a saturating counter of POS<->NEG reversals.
module sign_mon_chan
  import sign_mon_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STABLE = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clr,
  output logic             o_pos,
  output logic             o_neg,
  output logic             o_zero,
  output logic             o_flip,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int unsigned RunW = $clog2(STABLE + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(STABLE);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  cls_t             w_cls;
  cls_t             w_committed;
  cls_t             r_cand;
  logic [RunW-1:0]  r_run;
  logic [RunW-1:0]  w_run_next;
  logic [2:0]       r_flag;       // {neg, pos, zero}, always one-hot
  logic [2:0]       w_flag_next;
  logic             w_commit;
  logic             w_flip;
  logic             r_flip;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_cls = classify(i_data[WIDTH-1], |i_data);

    w_committed = CLS_ZERO;
    if (r_flag[1]) begin
      w_committed = CLS_POS;
    end else if (r_flag[2]) begin
      w_committed = CLS_NEG;
    end

    if (w_cls == r_cand) begin
      w_run_next = (r_run == RunMax) ? RunMax : r_run + 1'b1;
    end else begin
      w_run_next = RunW'(1);
    end

    w_commit = i_valid && (w_run_next == RunMax) && (w_cls != w_committed);
    // A changed commit with neither side ZERO can only be a direct POS<->NEG reversal.
    w_flip   = w_commit && (w_cls != CLS_ZERO) && (w_committed != CLS_ZERO);

    w_flag_next = 3'b001;
    unique case (w_cls)
      CLS_POS: w_flag_next = 3'b010;
      CLS_NEG: w_flag_next = 3'b100;
      default: w_flag_next = 3'b001;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cand <= CLS_ZERO;
      r_run  <= '0;
      r_flag <= 3'b001;
      r_flip <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_flip <= w_flip;
      if (i_valid) begin
        r_cand <= w_cls;
        r_run  <= w_run_next;
      end
      if (w_commit) begin
        r_flag <= w_flag_next;
      end
      if (i_clr) begin
        r_cnt <= '0;
      end else if (w_flip && (r_cnt != CntMax)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_zero = r_flag[0];
  assign o_pos  = r_flag[1];
  assign o_neg  = r_flag[2];
  assign o_flip = r_flip;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/sign_monitor_mc.sv
// Multi-channel sign monitor with persistence filtering. This level only slices the
// buses and fans out the shared valid and clear signals.
module sign_monitor_mc
  import sign_mon_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned STABLE   = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      clr_cnt,
  output logic [CHANNELS-1:0]       pos_flag,
  output logic [CHANNELS-1:0]       neg_flag,
  output logic [CHANNELS-1:0]       zero_flag,
  output logic [CHANNELS-1:0]       flip_pulse,
  output logic [CHANNELS*CNT_W-1:0] flip_count
);

  if (STABLE < 1 || STABLE > MAX_STABLE) begin : g_bad_stable
    $error("sign_monitor_mc: STABLE must be in 1..255");
  end

  if (WIDTH < 2 || CHANNELS < 1 || CNT_W < 1) begin : g_bad_dims
    $error("sign_monitor_mc: WIDTH >= 2, CHANNELS >= 1, CNT_W >= 1 required");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    sign_mon_chan #(
      .WIDTH  (WIDTH),
      .STABLE (STABLE),
      .CNT_W  (CNT_W)
    ) u_chan (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (in_valid),
      .i_data  (in_data[c*WIDTH +: WIDTH]),
      .i_clr   (clr_cnt),
      .o_pos   (pos_flag[c]),
      .o_neg   (neg_flag[c]),
      .o_zero  (zero_flag[c]),
      .o_flip  (flip_pulse[c]),
      .o_cnt   (flip_count[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/sign_monitor_mc.md
# sign_monitor_mc

Multi-channel, parametrised sign classifier with persistence filtering. Each channel classifies a signed two's-complement sample as positive, negative or zero. A channel commits a new class only after STABLE consecutive valid samples agree. Per-channel flags are registered and strictly one-hot, and direct positive/negative reversals are counted. It is the next generation of the single-channel 16-bit positive/negative flag block and sits between sample sources and downstream control that must not react to single-sample glitches.

## Interface
Parameters:
- WIDTH, 16, sample width in bits (signed two's complement, ≥2)
- CHANNELS, 4, number of independent channels (≥1)
- STABLE, 3, consecutive agreeing valid samples needed to commit a class (1..255)
- CNT_W, 8, width of each saturating flip counter (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  samples on in_data are accepted on this clk edge
- in_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- clr_cnt  in  1  synchronous clear of all flip counters
- pos_flag  out  CHANNELS  committed class is POS
- neg_flag  out  CHANNELS  committed class is NEG
- zero_flag  out  CHANNELS  committed class is ZERO
- flip_pulse  out  CHANNELS  one-cycle pulse on a committed POS↔NEG reversal
- flip_count  out  CHANNELS*CNT_W  per-channel saturating reversal count, channel c at [c*CNT_W +: CNT_W]

## Operation
- Classification, combinational, per sample:
  - NEG if the MSB is 1.
  - ZERO if all bits are 0.
  - POS otherwise.
  - -2^(WIDTH-1) → NEG; 2^(WIDTH-1)-1 → POS.
- Per-channel state: cand (2-bit class), run (0..STABLE, saturating), committed class, flip counter.
- On an edge with in_valid=1:
  - next_run = (cls==cand) ? min(run+1, STABLE) : 1.
  - cand ← cls; run ← next_run.
  - If next_run==STABLE, committed ← cls.
- On an edge with in_valid=0:
  - All state holds.
  - Invalid cycles neither break nor extend a run.
- Flags decode committed. Exactly one of pos/neg/zero is 1 per channel at all times, including during and after reset.
- Flip detection, on the edge where committed changes:
  - POS→NEG or NEG→POS: flip_pulse=1 for that cycle only; counter increments, saturating at 2^CNT_W-1.
  - Any transition through ZERO is not a flip.
- clr_cnt=1: all counters ← 0 on that edge. Clear wins over a simultaneous increment (result 0). flip_pulse is still asserted.
- Channels are fully independent. in_valid and clr_cnt are shared.
- STABLE=1: flags follow the previous accepted sample with one cycle latency, i.e. previous-generation behaviour.

## Timing
- Reset values, applied immediately on rst rise and independent of clk:
  - zero_flag all 1; pos_flag and neg_flag all 0.
  - flip_pulse 0; flip_count 0.
  - cand=ZERO, run=0.
- Reset mid-run discards the partial run. After reset, STABLE fresh samples are required to commit, including ZERO.
- Latency: flags and flip_pulse change on the same edge that accepts the STABLE-th consecutive agreeing sample. All outputs are registered, with no combinational input→output path.
- A sample repeating the committed class causes no output change and no pulse.

## Structure
- Package sign_mon_pkg:
  - typedef cls_t enum {CLS_ZERO=2'd0, CLS_POS=2'd1, CLS_NEG=2'd2}
  - function classify(sample) parametrised by width, or a WIDTH-generic localparam form
- Sub-module sign_mon_chan: one channel (classifier, run counter, committed register, flip counter), instantiated CHANNELS times via generate.
- Top level: slicing of in_data/flip_count and the shared in_valid/clr_cnt fan-out only.
- Elaboration-time check: 1 ≤ STABLE ≤ 255. Run counter width is $clog2(STABLE+1).

## Test plan
Configuration: WIDTH=16, CHANNELS=2, STABLE=3, CNT_W=4.
- Reset: assert rst between edges mid-run (ch0 after 10,10) → zero_flag=2'b11 immediately, counts 0. After release, two 10s leave zero_flag set; the third sets pos_flag[0].
- Persistence: ch0 valid 10,10,10 → pos_flag[0]=0 after edges 1–2, 1 after edge 3. Ch1 held at 0 keeps zero_flag[1]=1.
- Glitch rejection: ch0 committed POS, feed -5,-5,10,-5,-5,-5 → pos_flag stays 1 until the sixth sample's edge, then neg_flag=1. flip_pulse[0] is high exactly one cycle; flip_count ch0=1.
- Extremes/no-flip via zero: ch1 fed ×3 each of 32767, 0, -32768 → POS, ZERO, NEG in order; flip_pulse[1] never asserted, count 0.
- Valid gaps: ch0 10, five cycles in_valid=0 with data -5, then 10,10 → POS commits on the third valid 10. Invalid cycles cause no change.
- Saturation/clear: ch0 20 POS↔NEG commits → count saturates at 15. Then clr_cnt coincident with a flip → count 0, flip_pulse[0]=1. Ch1 count unaffected by ch0 activity.
